// File: rtl/flight_attendant_call_arbiter.sv
// Cabin call controller: per-seat call lights plus a round-robin dispatcher to one attendant.
// Optional offer-timeout escalation is built only when CALL_ESCALATE_EN is defined.
module flight_attendant_call_arbiter #(
    parameter int NUM_SEATS  = 8,
    parameter int IDX_W      = 3,
    parameter int ESC_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SEATS-1:0] call_button,
    input  logic [NUM_SEATS-1:0] cancel_button,
    input  logic                 attendant_ready,
    input  logic                 attendant_done,
    output logic [NUM_SEATS-1:0] seat_light,
    output logic                 dispatch_valid,
    output logic [IDX_W-1:0]     dispatch_seat,
    output logic                 busy,
    output logic                 escalate
);

    localparam int SEL_W = $clog2(NUM_SEATS);

    if (NUM_SEATS < 2 || (1 << IDX_W) < NUM_SEATS || ESC_CYCLES < 1) begin : g_param_check
        $error("flight_attendant_call_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, SERVICE = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [NUM_SEATS-1:0] light_q, light_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [IDX_W-1:0]     seat_q, seat_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 transfer;
    logic                 offer_cancel;

    assign transfer     = (state_q == OFFER) && attendant_ready;
    assign offer_cancel = (state_q == OFFER) && !attendant_ready && !light_d[SEL_W'(seat_q)];

    // The seat being handed over or in service is pinned on; everyone else latches normally.
    for (genvar gi = 0; gi < NUM_SEATS; gi++) begin : g_seat
        logic served;
        assign served = (seat_q == IDX_W'(gi)) && ((state_q == SERVICE) || transfer);
        assign light_d[gi] = served
            ? ((state_q == SERVICE && attendant_done) ? call_button[gi] : 1'b1)
            : (call_button[gi] | (~cancel_button[gi] & light_q[gi]));
    end

    always_comb begin
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= NUM_SEATS; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_SEATS;
            if (!pick_found && light_q[SEL_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            light_q      <= '0;
            last_grant_q <= IDX_W'(NUM_SEATS - 1);
            seat_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            light_q      <= light_d;
            last_grant_q <= last_grant_d;
            seat_q       <= seat_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = OFFER;
            OFFER: begin
                if (attendant_ready)   state_d = SERVICE;
                else if (offer_cancel) state_d = IDLE;
            end
            SERVICE: if (attendant_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        seat_d       = seat_q;
        valid_d      = valid_q;
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    seat_d  = pick_idx;
                    valid_d = 1'b1;
                end
            end
            OFFER: begin
                if (attendant_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                end else if (offer_cancel) begin
                    valid_d = 1'b0;
                end
            end
            SERVICE: begin
                if (attendant_done) begin
                    busy_d       = 1'b0;
                    last_grant_d = seat_q;
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign seat_light     = light_q;
    assign dispatch_valid = valid_q;
    assign dispatch_seat  = seat_q;
    assign busy           = busy_q;

`ifdef CALL_ESCALATE_EN
    localparam int CNT_W = $clog2(ESC_CYCLES + 1);

    logic [CNT_W-1:0] esc_cnt_q, esc_cnt_d;
    logic             escalate_q, escalate_d;

    // OFFER is only entered from IDLE, so holding the count at zero there clears it on entry.
    always_comb begin
        esc_cnt_d  = esc_cnt_q;
        escalate_d = 1'b0;
        if (state_q == IDLE) begin
            esc_cnt_d = '0;
        end else if (state_q == OFFER && state_d == OFFER) begin
            if (esc_cnt_q != CNT_W'(ESC_CYCLES)) esc_cnt_d = esc_cnt_q + 1'b1;
            escalate_d = (esc_cnt_d == CNT_W'(ESC_CYCLES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            esc_cnt_q  <= '0;
            escalate_q <= 1'b0;
        end else begin
            esc_cnt_q  <= esc_cnt_d;
            escalate_q <= escalate_d;
        end
    end

    assign escalate = escalate_q;
`else
    assign escalate = 1'b0;
`endif

endmodule

// File: tb/tb_flight_attendant_call_arbiter.sv
// Self-checking bench for flight_attendant_call_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the cabin call rules.
module tb_flight_attendant_call_arbiter;

    localparam int N   = 8;
    localparam int IW  = 3;
    localparam int ESC = 4;
`ifdef CALL_ESCALATE_EN
    localparam bit ESC_ON = 1'b1;
`else
    localparam bit ESC_ON = 1'b0;
`endif
    localparam int S_IDLE = 0, S_OFFER = 1, S_SERVICE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  call_button = '0;
    logic [N-1:0]  cancel_button = '0;
    logic          attendant_ready = 1'b0;
    logic          attendant_done = 1'b0;
    logic [N-1:0]  seat_light;
    logic          dispatch_valid;
    logic [IW-1:0] dispatch_seat;
    logic          busy;
    logic          escalate;

    int errors = 0;
    int checks = 0;

    // behavioural model
    logic [N-1:0] m_light;
    int           m_state, m_seat, m_last, m_cnt;
    bit           m_valid, m_busy, m_esc;

    flight_attendant_call_arbiter #(
        .NUM_SEATS(N), .IDX_W(IW), .ESC_CYCLES(ESC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .call_button(call_button), .cancel_button(cancel_button),
        .attendant_ready(attendant_ready), .attendant_done(attendant_done),
        .seat_light(seat_light), .dispatch_valid(dispatch_valid),
        .dispatch_seat(dispatch_seat), .busy(busy), .escalate(escalate)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_light = '0; m_state = S_IDLE; m_seat = 0; m_last = N - 1;
        m_cnt = 0; m_valid = 1'b0; m_busy = 1'b0; m_esc = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, clock, and settle 1ns past the edge.
    task automatic step(input logic [N-1:0] call, input logic [N-1:0] cancel,
                        input bit rdy, input bit done);
        logic [N-1:0] nl;
        bit found;
        call_button = call; cancel_button = cancel;
        attendant_ready = rdy; attendant_done = done;
        for (int i = 0; i < N; i++) begin
            if (m_state == S_SERVICE && i == m_seat)
                nl[i] = done ? call[i] : 1'b1;
            else if (m_state == S_OFFER && rdy && i == m_seat)
                nl[i] = 1'b1;
            else
                nl[i] = call[i] | (~cancel[i] & m_light[i]);
        end
        if (m_state == S_IDLE) begin
            if (m_light != 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && m_light[(m_last + k) % N]) begin
                        found = 1'b1;
                        m_seat = (m_last + k) % N;
                    end
                end
                m_valid = 1'b1; m_state = S_OFFER; m_cnt = 0; m_esc = 1'b0;
            end
        end else if (m_state == S_OFFER) begin
            if (rdy) begin
                m_valid = 1'b0; m_busy = 1'b1; m_state = S_SERVICE; m_esc = 1'b0;
            end else if (!nl[m_seat]) begin
                m_valid = 1'b0; m_state = S_IDLE; m_esc = 1'b0;
            end else begin
                if (m_cnt < ESC) m_cnt++;
                m_esc = ESC_ON && (m_cnt >= ESC);
            end
        end else if (done) begin
            m_last = m_seat; m_busy = 1'b0; m_state = S_IDLE;
        end
        m_light = nl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        call_button = '0; cancel_button = '0; attendant_ready = 1'b0; attendant_done = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (seat_light !== 8'h00) begin errors++; $display("FAIL reset_light: got %h expected 00", seat_light); end
        checks++; if (dispatch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dispatch_valid); end
        checks++; if (dispatch_seat !== 3'd0) begin errors++; $display("FAIL reset_seat: got %0d expected 0", dispatch_seat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (escalate !== 1'b0) begin errors++; $display("FAIL reset_escalate: got %b expected 0", escalate); end
        model_reset();
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single_call();
        step(8'h08, 8'h00, 1'b0, 1'b0);
        checks++; if (seat_light !== 8'h08 || dispatch_valid !== 1'b0) begin errors++; $display("FAIL single_latch: light=%h valid=%b expected light=08 valid=0", seat_light, dispatch_valid); end
        step(8'h00, 8'h00, 1'b1, 1'b0);
        checks++; if (dispatch_valid !== 1'b1 || dispatch_seat !== 3'd3 || busy !== 1'b0) begin errors++; $display("FAIL single_offer: valid=%b seat=%0d busy=%b expected 1/3/0", dispatch_valid, dispatch_seat, busy); end
        step(8'h00, 8'h00, 1'b1, 1'b0);
        checks++; if (busy !== 1'b1 || dispatch_valid !== 1'b0 || seat_light !== 8'h08) begin errors++; $display("FAIL single_transfer: busy=%b valid=%b light=%h expected 1/0/08", busy, dispatch_valid, seat_light); end
        step(8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_hold: busy=%b expected 1", busy); end
        step(8'h00, 8'h00, 1'b0, 1'b1);
        checks++; if (seat_light !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL single_done: light=%h busy=%b expected 00/0", seat_light, busy); end
        $display("test_single_call done");
    endtask

    task automatic test_round_robin();
        int got[$];
        int exp_order[4] = '{1, 5, 1, 5};
        logic [N-1:0] recall;
        bit prev_busy, do_done;
        int s;
        do_reset();
        step(8'h22, 8'h00, 1'b0, 1'b0);
        recall = '0;
        prev_busy = 1'b0;
        for (int cyc = 0; cyc < 60 && got.size() < 4; cyc++) begin
            do_done = busy;
            s = int'(dispatch_seat);
            step(recall, 8'h00, 1'b1, do_done);
            recall = do_done ? (N'(1) << s) : '0;
            if (busy && !prev_busy) got.push_back(int'(dispatch_seat));
            prev_busy = busy;
        end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL rr_count: got %0d dispatches expected 4 within budget", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] != exp_order[i]) begin errors++; $display("FAIL rr_order[%0d]: got seat %0d expected %0d", i, got[i], exp_order[i]); end
        end
        $display("test_round_robin done: %0d dispatches", got.size());
    endtask

    task automatic test_offer_cancel();
        do_reset();
        step(8'h10, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b0);
        checks++; if (dispatch_valid !== 1'b1 || dispatch_seat !== 3'd4) begin errors++; $display("FAIL cancel_offer: valid=%b seat=%0d expected 1/4", dispatch_valid, dispatch_seat); end
        step(8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h10, 1'b0, 1'b0);
        checks++; if (dispatch_valid !== 1'b0 || seat_light !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL cancel_drop: valid=%b light=%h busy=%b expected 0/00/0", dispatch_valid, seat_light, busy); end
        // seats 0 and 5 together: 0 wins only if last_grant is still 7
        step(8'h21, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b0);
        checks++; if (dispatch_valid !== 1'b1 || dispatch_seat !== 3'd0) begin errors++; $display("FAIL cancel_last_grant: valid=%b seat=%0d expected 1/0", dispatch_valid, dispatch_seat); end
        $display("test_offer_cancel done");
    endtask

    task automatic test_call_cancel_same();
        do_reset();
        step(8'h04, 8'h04, 1'b0, 1'b0);
        checks++; if (seat_light !== 8'h04) begin errors++; $display("FAIL same_edge_light: got %h expected 04", seat_light); end
        step(8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h04, 1'b1, 1'b0);
        checks++; if (busy !== 1'b1 || seat_light !== 8'h04) begin errors++; $display("FAIL cancel_vs_ready: busy=%b light=%h expected 1/04", busy, seat_light); end
        step(8'h00, 8'h04, 1'b0, 1'b0);
        step(8'h00, 8'h04, 1'b0, 1'b0);
        checks++; if (seat_light !== 8'h04) begin errors++; $display("FAIL service_cancel_ignored: light=%h expected 04", seat_light); end
        step(8'h04, 8'h00, 1'b0, 1'b1);
        checks++; if (seat_light !== 8'h04 || busy !== 1'b0) begin errors++; $display("FAIL done_repend: light=%h busy=%b expected 04/0", seat_light, busy); end
        step(8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        checks++; if (seat_light !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL done_clear: light=%h busy=%b expected 00/0", seat_light, busy); end
        $display("test_call_cancel_same done");
    endtask

    task automatic test_async_reset();
        do_reset();
        step(8'h80, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL async_setup: busy=%b expected 1", busy); end
        #2;
        call_button = 8'h01;
        attendant_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({seat_light, dispatch_valid, dispatch_seat, busy, escalate} !== 14'h0) begin errors++; $display("FAIL async_clear: light=%h valid=%b seat=%0d busy=%b esc=%b expected all 0", seat_light, dispatch_valid, dispatch_seat, busy, escalate); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h81, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b0);
        checks++; if (dispatch_valid !== 1'b1 || dispatch_seat !== 3'd0) begin errors++; $display("FAIL async_first_seat: valid=%b seat=%0d expected 1/0", dispatch_valid, dispatch_seat); end
        $display("test_async_reset done");
    endtask

    task automatic test_escalate();
        do_reset();
        step(8'h40, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b0);
        checks++; if (dispatch_valid !== 1'b1 || dispatch_seat !== 3'd6) begin errors++; $display("FAIL esc_offer: valid=%b seat=%0d expected 1/6", dispatch_valid, dispatch_seat); end
        repeat (3) step(8'h00, 8'h00, 1'b0, 1'b0);
        checks++; if (escalate !== 1'b0) begin errors++; $display("FAIL esc_early: got %b expected 0", escalate); end
        step(8'h00, 8'h00, 1'b0, 1'b0);
        checks++; if (escalate !== ESC_ON) begin errors++; $display("FAIL esc_assert: got %b expected %b", escalate, ESC_ON); end
        repeat (3) step(8'h00, 8'h00, 1'b0, 1'b0);
        checks++; if (escalate !== ESC_ON) begin errors++; $display("FAIL esc_hold: got %b expected %b", escalate, ESC_ON); end
        step(8'h00, 8'h00, 1'b1, 1'b0);
        checks++; if (escalate !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL esc_release: esc=%b busy=%b expected 0/1", escalate, busy); end
        $display("test_escalate done");
    endtask

    task automatic test_random();
        logic [N-1:0] call, cancel;
        bit rdy, done;
        do_reset();
        for (int t = 0; t < 500; t++) begin
            call   = N'($urandom & $urandom & $urandom);
            cancel = N'($urandom & $urandom & $urandom);
            rdy    = ($urandom_range(1, 0) == 1);
            done   = ($urandom_range(2, 0) == 0);
            step(call, cancel, rdy, done);
            checks++;
            if ({seat_light, dispatch_valid, dispatch_seat, busy, escalate} !==
                {m_light, m_valid, IW'(m_seat), m_busy, m_esc}) begin
                errors++;
                $display("FAIL random[%0d]: light=%h valid=%b seat=%0d busy=%b esc=%b expected light=%h valid=%b seat=%0d busy=%b esc=%b",
                         t, seat_light, dispatch_valid, dispatch_seat, busy, escalate,
                         m_light, m_valid, m_seat, m_busy, m_esc);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_call();
        test_round_robin();
        test_offer_cancel();
        test_call_cancel_same();
        test_async_reset();
        test_escalate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
